// File: rtl/toggle_cover_sched_if.sv
// Handshake bundle between the toggle monitors, the scheduler and the
// coverage reporter: per-cycle hit vectors in, one cover index per transfer out.
interface toggle_cover_sched_if #(
    parameter int NUM_GROUPS = 4,
    parameter int GROUP_W    = 32,
    parameter int IDX_W      = 32
);
    logic [NUM_GROUPS*GROUP_W-1:0] hit;
    logic                          out_valid;
    logic                          out_ready;
    logic [IDX_W-1:0]              out_index;

    // Monitor/reporter side: drives hits and ready, observes events.
    modport master (
        output hit,
        output out_ready,
        input  out_valid,
        input  out_index
    );

    // Scheduler side.
    modport slave (
        input  hit,
        input  out_ready,
        output out_valid,
        output out_index
    );
endinterface

// File: rtl/toggle_cover_sched.sv
// Toggle-coverage event scheduler.
// Collects sticky hits from NUM_GROUPS monitor groups, picks one point per
// load (round-robin across groups, lowest bit within a group) and presents it
// on a valid/ready channel as COVER_BASE + group*GROUP_W + bit.
// Optional feature: define TOGGLE_COVER_DEDUP_EN to keep a "seen" bitmap so
// each point is reported at most once between resets.
module toggle_cover_sched #(
    parameter int          NUM_GROUPS = 4,
    parameter int          GROUP_W    = 32,
    parameter int unsigned COVER_BASE = 0,
    parameter int          IDX_W      = 32,
    localparam int         NPTS       = NUM_GROUPS * GROUP_W,
    localparam int         CNT_W      = $clog2(NPTS + 1)
) (
    input  logic                     gbl_clk,
    input  logic                     reset,
    toggle_cover_sched_if.slave      bus,
    output logic [CNT_W-1:0]         covered_cnt,
    output logic                     busy
);

    localparam int PTR_W = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;
    localparam int BIT_W = (GROUP_W > 1) ? $clog2(GROUP_W) : 1;

    logic [NPTS-1:0]    pending;
    logic [NPTS-1:0]    pending_nxt;
    logic [NPTS-1:0]    load_mask;
    logic [NPTS-1:0]    hit_mask;
    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   sel_grp;
    logic [BIT_W-1:0]   sel_bit;
    logic [GROUP_W-1:0] sel_word;
    logic [IDX_W-1:0]   sel_index;
    logic               sel_found;
    logic               load;
    logic               take;

    // Output register is free when empty or when the current event is accepted.
    assign load = !bus.out_valid || bus.out_ready;
    assign take = load && sel_found;

    // Group search: first group at or after rr_ptr (with wrap) holding a pending hit.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        sel_found = 1'b0;
        sel_grp   = '0;
        for (int k = 0; k < NUM_GROUPS; k++) begin
            if (!sel_found &&
                (|pending[((int'(rr_ptr) + k) % NUM_GROUPS) * GROUP_W +: GROUP_W])) begin
                sel_found = 1'b1;
                sel_grp   = PTR_W'((int'(rr_ptr) + k) % NUM_GROUPS);
            end
        end
    end

    // Bit search: lowest set bit inside the selected group's pending word.
    always_comb begin
        sel_word = pending[int'(sel_grp) * GROUP_W +: GROUP_W];
        sel_bit  = '0;
        for (int b = GROUP_W - 1; b >= 0; b--) begin
            if (sel_word[b]) begin
                sel_bit = BIT_W'(b);
            end
        end
    end

    // Cover index of the selected point; wraps modulo 2^IDX_W.
    assign sel_index = IDX_W'(COVER_BASE) + IDX_W'(int'(sel_grp) * GROUP_W + int'(sel_bit));

    // One-hot mask of the point moving into the output register this cycle.
    always_comb begin
        load_mask = '0;
        if (take) begin
            load_mask[int'(sel_grp) * GROUP_W + int'(sel_bit)] = 1'b1;
        end
    end

`ifdef TOGGLE_COVER_DEDUP_EN
    logic [NPTS-1:0] seen;

    // Anything ever loaded, or being loaded now, is blocked from re-pending.
    assign hit_mask = seen | load_mask;

    // Seen bitmap accumulates every loaded point until reset.
    always_ff @(posedge gbl_clk) begin
        if (!reset) begin
            seen <= '0;
        end else begin
            seen <= seen | load_mask;
        end
    end
`else
    assign hit_mask = '0;
`endif

    // Sticky pending: drop the loaded point, merge new hits (coalescing repeats).
    assign pending_nxt = (pending & ~load_mask) | (bus.hit & ~hit_mask);

    // Pending bitmap, round-robin pointer and output register.
    always_ff @(posedge gbl_clk) begin
        // NOTE: the pending bitmap is cleared on reset like any other state; it is flops, not a RAM, so this is cheap and removes stale hits.
        if (!reset) begin
            pending       <= '0;
            rr_ptr        <= '0;
            bus.out_valid <= 1'b0;
            bus.out_index <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            pending <= pending_nxt;
            if (load) begin
                bus.out_valid <= sel_found;
                if (sel_found) begin
                    bus.out_index <= sel_index;
                    rr_ptr        <= (int'(sel_grp) == NUM_GROUPS - 1) ? '0 : sel_grp + 1'b1;
                end
            end
        end
    end

    // Completed handshakes since reset, saturating at all-ones.
    always_ff @(posedge gbl_clk) begin
        if (!reset) begin
            covered_cnt <= '0;
        end else if (bus.out_valid && bus.out_ready && (covered_cnt != '1)) begin
            covered_cnt <= covered_cnt + 1'b1;
        end
    end

    assign busy = (|pending) || bus.out_valid;

endmodule

// File: tb/tb_toggle_cover_sched.sv
// Self-checking bench for toggle_cover_sched: directed stimulus with a
// scoreboard queue of expected cover indices, popped on every handshake.
module tb_toggle_cover_sched;

    localparam int NUM_GROUPS = 4;
    localparam int GROUP_W    = 32;
    localparam int IDX_W      = 32;
    localparam int CNT_W      = $clog2(NUM_GROUPS * GROUP_W + 1);

    logic             gbl_clk;
    logic             reset;
    logic [CNT_W-1:0] covered_cnt;
    logic             busy;

    int n_tests;
    int n_fail;
    int exp_q[$];

    toggle_cover_sched_if #(
        .NUM_GROUPS (NUM_GROUPS),
        .GROUP_W    (GROUP_W),
        .IDX_W      (IDX_W)
    ) dut_if ();

    toggle_cover_sched #(
        .NUM_GROUPS (NUM_GROUPS),
        .GROUP_W    (GROUP_W),
        .COVER_BASE (0),
        .IDX_W      (IDX_W)
    ) dut (
        .gbl_clk     (gbl_clk),
        .reset       (reset),
        .bus         (dut_if.slave),
        .covered_cnt (covered_cnt),
        .busy        (busy)
    );

    initial gbl_clk = 1'b0;
    always #5 gbl_clk = ~gbl_clk;

    task automatic check(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    // Scoreboard: every accepted event must match the oldest expected index.
    always @(negedge gbl_clk) begin
        if (reset && dut_if.out_valid && dut_if.out_ready) begin
            if (exp_q.size() == 0) begin
                check("spurious_event", 64'(dut_if.out_index), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                check("event_index", 64'(dut_if.out_index), 64'(exp_q.pop_front()));
            end
        end
    end

    task automatic step();
        @(posedge gbl_clk);
        #1;
    endtask

    task automatic do_reset();
        reset            = 1'b0;
        dut_if.hit       = '0;
        dut_if.out_ready = 1'b0;
        step();
        step();
        exp_q.delete();
        reset = 1'b1;
    endtask

    task automatic pulse_bit(input int idx);
        dut_if.hit      = '0;
        dut_if.hit[idx] = 1'b1;
        step();
        dut_if.hit = '0;
    endtask

    // Run until scoreboard empty and DUT idle, bounded by a cycle budget.
    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 300) begin
            step();
            n++;
        end
        check({tag, "_drain_q"}, 64'(exp_q.size()), 64'd0);
        check({tag, "_drain_busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b0;
        dut_if.hit       = '0;
        dut_if.out_ready = 1'b0;
        #2;

        // Reset values.
        do_reset();
        check("rst_valid", 64'(dut_if.out_valid), 64'd0);
        check("rst_index", 64'(dut_if.out_index), 64'd0);
        check("rst_cnt", 64'(covered_cnt), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);

        // Single hit on bit 37: valid exactly one cycle, two cycles after the hit edge.
        dut_if.out_ready = 1'b1;
        exp_q.push_back(37);
        pulse_bit(37);
        check("single_lat1_valid", 64'(dut_if.out_valid), 64'd0);
        step();
        check("single_valid", 64'(dut_if.out_valid), 64'd1);
        check("single_index", 64'(dut_if.out_index), 64'd37);
        step();
        check("single_valid_drop", 64'(dut_if.out_valid), 64'd0);
        check("single_cnt", 64'(covered_cnt), 64'd1);
        check("single_busy", 64'(busy), 64'd0);

        // Round-robin across groups, one event per cycle.
        do_reset();
        dut_if.out_ready = 1'b1;
        foreach (exp_q[i]) ; // queue empty after reset
        exp_q.push_back(0);
        exp_q.push_back(32);
        exp_q.push_back(64);
        exp_q.push_back(96);
        dut_if.hit     = '0;
        dut_if.hit[0]  = 1'b1;
        dut_if.hit[32] = 1'b1;
        dut_if.hit[64] = 1'b1;
        dut_if.hit[96] = 1'b1;
        step();
        dut_if.hit = '0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("rr_valid", 64'(dut_if.out_valid), 64'd1);
            check("rr_index", 64'(dut_if.out_index), 64'(32 * i));
        end
        step();
        check("rr_valid_drop", 64'(dut_if.out_valid), 64'd0);
        check("rr_cnt", 64'(covered_cnt), 64'd4);

        // Backpressure: index held stable while stalled.
        do_reset();
        dut_if.out_ready = 1'b0;
        exp_q.push_back(5);
        exp_q.push_back(6);
        dut_if.hit    = '0;
        dut_if.hit[5] = 1'b1;
        dut_if.hit[6] = 1'b1;
        step();
        dut_if.hit = '0;
        for (int i = 0; i < 10; i++) begin
            step();
            check("bp_valid", 64'(dut_if.out_valid), 64'd1);
            check("bp_index", 64'(dut_if.out_index), 64'd5);
        end
        check("bp_cnt_stalled", 64'(covered_cnt), 64'd0);
        dut_if.out_ready = 1'b1;
        drain("bp");
        check("bp_cnt", 64'(covered_cnt), 64'd2);

        // Three separate bursts on bit 9.
        do_reset();
        dut_if.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
`ifdef TOGGLE_COVER_DEDUP_EN
            if (i == 0) exp_q.push_back(9);
`else
            exp_q.push_back(9);
`endif
            pulse_bit(9);
            drain("dedup");
        end
`ifdef TOGGLE_COVER_DEDUP_EN
        check("dedup_cnt", 64'(covered_cnt), 64'd1);
`else
        check("dedup_cnt", 64'(covered_cnt), 64'd3);
`endif

        // Coalescing: bit 3 held for 5 cycles under backpressure.
        // Without dedup the hit after the first load re-pends the point once.
        do_reset();
        dut_if.out_ready = 1'b0;
        exp_q.push_back(3);
`ifndef TOGGLE_COVER_DEDUP_EN
        exp_q.push_back(3);
`endif
        dut_if.hit    = '0;
        dut_if.hit[3] = 1'b1;
        for (int i = 0; i < 5; i++) step();
        dut_if.hit = '0;
        check("coal_index_held", 64'(dut_if.out_index), 64'd3);
        dut_if.out_ready = 1'b1;
        drain("coal");
`ifdef TOGGLE_COVER_DEDUP_EN
        check("coal_cnt", 64'(covered_cnt), 64'd1);
`else
        check("coal_cnt", 64'(covered_cnt), 64'd2);
`endif

        // Reset in the middle of a stream of events.
        do_reset();
        dut_if.out_ready = 1'b1;
        exp_q.push_back(1);
        exp_q.push_back(2);
        dut_if.hit = '0;
        for (int b = 1; b <= 8; b++) dut_if.hit[b] = 1'b1;
        step();
        dut_if.hit = '0;
        step();
        step();
        step();
        check("mid_cnt_before", 64'(covered_cnt), 64'd2);
        check("mid_index_before", 64'(dut_if.out_index), 64'd3);
        reset = 1'b0;
        step();
        check("mid_rst_valid", 64'(dut_if.out_valid), 64'd0);
        check("mid_rst_cnt", 64'(covered_cnt), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        // Hits while in reset are ignored.
        dut_if.hit    = '0;
        dut_if.hit[7] = 1'b1;
        step();
        dut_if.hit = '0;
        exp_q.delete();
        reset = 1'b1;
        check("mid_ign_busy", 64'(busy), 64'd0);
        exp_q.push_back(2);
        pulse_bit(2);
        drain("mid");
        check("mid_cnt_after", 64'(covered_cnt), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
